// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and helpers for the FIFO write-port arbiter.
//   - arb_state_e : arbiter FSM state (IDLE / BURST), 1-bit encoding
//   - id_width()  : width of a requester index for a given requester count
package fifo_arb_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_BURST = 1'b1;

  typedef enum logic {
    IDLE  = ST_IDLE,
    BURST = ST_BURST
  } arb_state_e;

  // A single requester still needs a 1-bit index so ports never collapse to zero width.
  function automatic int id_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req    : request vector, one bit per requester
//   rr_ptr : highest-priority index for this pick
//   pick   : first set bit of req searching rr_ptr, rr_ptr+1, ... (mod NUM_REQ)
//   any    : at least one request is set
// The request vector is doubled and shifted down by rr_ptr so the search
// becomes a plain lowest-bit priority encode; the offset is then mapped back.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] rr_ptr,
  output logic [ID_WIDTH-1:0] pick,
  output logic                any
);

  logic [NUM_REQ-1:0] rot;
  logic               found;
  int                 idx;

  // NOTE: combinational logic uses blocking assignments, and every variable
  // written here gets a default first so no latch can be inferred.
  always_comb begin
    rot   = NUM_REQ'({req, req} >> rr_ptr);
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        idx   = int'(rr_ptr) + i;
        // Explicit wrap so non-power-of-2 requester counts stay in range.
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        pick  = ID_WIDTH'(idx);
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: shares one async-FIFO write port among NUM_REQ requesters
// in the write clock domain, round-robin with bursts of up to MAX_BURST beats.
//   wr_clk, wr_rst_n : write-domain clock, async active-low reset
//   req_vld/req_data : per-requester beat valid and packed beat data
//   req_rdy          : combinational accept, only ever set for the owner
//   fifo_full/afull  : FIFO flags (afull at DEPTH-1)
//   fifo_wr_en/data  : registered FIFO write strobe and data
//   gnt_vld/gnt_id   : a burst is in progress / current owner
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 4,
  parameter  int MAX_BURST  = 4,
  localparam int ID_WIDTH   = id_width(NUM_REQ)
) (
  input  logic                          wr_clk,
  input  logic                          wr_rst_n,
  input  logic [NUM_REQ-1:0]            req_vld,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_rdy,
  input  logic                          fifo_full,
  input  logic                          fifo_afull,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic                          gnt_vld,
  output logic [ID_WIDTH-1:0]           gnt_id
);

  localparam int                  CNT_WIDTH = $clog2(MAX_BURST + 1);
  localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(MAX_BURST - 1);
  localparam logic [ID_WIDTH-1:0]  LAST_ID   = ID_WIDTH'(NUM_REQ - 1);

  arb_state_e            state, state_nxt;
  logic [ID_WIDTH-1:0]   rr_ptr, rr_ptr_nxt;
  logic [ID_WIDTH-1:0]   gnt_id_nxt, pick;
  logic [CNT_WIDTH-1:0]  beat_cnt, beat_cnt_nxt;
  logic                  any_req, owner_vld, accept_ok, beat;
  logic [DATA_WIDTH-1:0] owner_data;

  rr_pick #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr_pick (
    .req    (req_vld),
    .rr_ptr (rr_ptr),
    .pick   (pick),
    .any    (any_req)
  );

  assign gnt_vld    = (state == BURST);
  assign owner_vld  = req_vld[gnt_id];
  assign owner_data = req_data[gnt_id*DATA_WIDTH +: DATA_WIDTH];

  // Almost-full only blocks while a registered write is still in flight:
  // that write takes the last free slot, so nothing else may be accepted.
  assign accept_ok = ~fifo_full & ~(fifo_afull & fifo_wr_en);
  assign beat      = gnt_vld & owner_vld & accept_ok;

  always_comb begin
    req_rdy = '0;
    if (beat) req_rdy[gnt_id] = 1'b1;
  end

  always_comb begin
    state_nxt    = state;
    gnt_id_nxt   = gnt_id;
    rr_ptr_nxt   = rr_ptr;
    beat_cnt_nxt = beat_cnt;
    case (state)
      IDLE: begin
        if (any_req) begin
          gnt_id_nxt   = pick;
          beat_cnt_nxt = '0;
          state_nxt    = BURST;
        end
      end
      BURST: begin
        if (beat) beat_cnt_nxt = beat_cnt + 1'b1;
        // A stall (owner valid, no accept) matches neither term, so the burst holds.
        // Limit and owner-drop in the same cycle collapse into a single exit.
        if (!owner_vld || (beat && (beat_cnt == LAST_BEAT))) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = (gnt_id == LAST_ID) ? '0 : gnt_id + 1'b1;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; these are all
  // control/data registers (no storage array), so every one takes the reset.
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      beat_cnt     <= '0;
      gnt_id       <= '0;
      fifo_wr_en   <= 1'b0;
      fifo_wr_data <= '0;
    end else begin
      state      <= state_nxt;
      rr_ptr     <= rr_ptr_nxt;
      beat_cnt   <= beat_cnt_nxt;
      gnt_id     <= gnt_id_nxt;
      fifo_wr_en <= beat;
      if (beat) fifo_wr_data <= owner_data;
    end
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the single write port of an async_fifo (write-clock domain) among NUM_REQ requesters, using round-robin grants with bounded bursts.
- Drives registered fifo_wr_en/fifo_wr_data, and throttles on the FIFO's full/afull flags so the FIFO never sees a write while full.
- Sits entirely in the FIFO's write clock domain; the read side is untouched.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- DATA_WIDTH, 4, beat width; equals the FIFO's DATA_WIDTH.
- MAX_BURST, 4, maximum beats per grant (>=1).
- ID_WIDTH, $clog2(NUM_REQ), width of the grant id (localparam).

Ports:
- wr_clk  in  1  write-domain clock.
- wr_rst_n  in  1  reset, asynchronous assert, active-low.
- req_vld  in  NUM_REQ  per-requester beat valid.
- req_data  in  NUM_REQ*DATA_WIDTH  packed beats; requester i occupies [i*DATA_WIDTH +: DATA_WIDTH].
- req_rdy  out  NUM_REQ  per-requester beat accepted (combinational).
- fifo_full  in  1  FIFO full flag.
- fifo_afull  in  1  FIFO almost-full flag; FIFO configured with FIFO_AFULL = FIFO_DEPTH-1.
- fifo_wr_en  out  1  registered FIFO write enable.
- fifo_wr_data  out  DATA_WIDTH  registered FIFO write data.
- gnt_vld  out  1  a burst is in progress.
- gnt_id  out  ID_WIDTH  current owner index.

Behaviour:
- Clock and reset: single clock wr_clk; reset is asynchronous and active-low (wr_rst_n).
- Reset values: state=IDLE, rr_ptr=0, beat_cnt=0, fifo_wr_en=0, fifo_wr_data=0, gnt_vld=0, gnt_id=0.
- Reset asserted mid-burst aborts the burst immediately. Beats not yet accepted are not written. A beat already registered in fifo_wr_en is cleared by the reset.
- accept_ok = ~fifo_full & ~(fifo_afull & fifo_wr_en). This reserves one slot for the in-flight registered write.
- beat = gnt_vld & req_vld[gnt_id] & accept_ok.
- req_rdy[i] = beat & (i == gnt_id); all other bits are 0.
- Each cycle: fifo_wr_en <= beat; fifo_wr_data <= req_data[gnt_id] when beat, otherwise it holds its value.
- Latency: the accepted beat appears on fifo_wr_en one cycle after the req_vld/req_rdy handshake.
- IDLE state:
  - gnt_vld=0.
  - If |req_vld, the round-robin pick is the first set bit searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - On the next edge: gnt_id <= pick, beat_cnt <= 0, go to BURST.
  - There is one arbitration cycle with no beat.
- BURST state (gnt_vld=1):
  - On beat, beat_cnt increments.
  - Exit to IDLE when (beat & beat_cnt == MAX_BURST-1) or ~req_vld[gnt_id]. A requester dropping valid ends its burst.
  - On exit, rr_ptr <= (gnt_id+1) mod NUM_REQ.
  - While stalled (req_vld[gnt_id]=1 and accept_ok=0), the burst holds: no exit and no count change.
- Fairness: after a burst, the just-served requester has lowest priority. No requester waits more than (NUM_REQ-1) bursts.
- Requester rule: req_data must be stable while req_vld=1 and req_rdy=0. req_vld changes of non-owners are ignored until the next IDLE.
- Widths: beat_cnt is $clog2(MAX_BURST+1) bits. rr_ptr wraps from NUM_REQ-1 to 0; this is explicit for non-power-of-2 NUM_REQ.
- Simultaneous events:
  - The last burst beat together with fifo_afull: the beat is taken only if accept_ok.
  - Owner valid dropping in the same cycle as the count limit: exit once; rr_ptr is updated once.

Decomposition:
- Package fifo_arb_pkg holds:
  - state enum {IDLE, BURST}, encoded as 1-bit localparams.
  - a function returning the ID_WIDTH for a NUM_REQ.
- Sub-module rr_pick (combinational, parameter NUM_REQ):
  - inputs: req vector, rr_ptr.
  - outputs: pick index, any.
  - implemented as a double-width rotate-and-priority-encode.

Test Plan:
- Single requester 2 streams 6 beats (fifo flags 0), MAX_BURST=4 → gnt_id=2; 4 beats, IDLE bubble, 2 beats; fifo_wr_en pattern 1111_0_11, each one cycle after req_rdy; data order preserved.
- All 4 requesters hold req_vld=1 continuously from reset → grant order 0,1,2,3,0; each gets exactly 4 beats.
- Owner 1 drops req_vld after 2 beats while 3 is waiting → burst ends; next grant is 3; rr_ptr=2 before the pick; requester 1 gets only 2 writes.
- fifo_afull=1 while fifo_wr_en=1 → req_rdy=0 next cycle; no write until afull deasserts or the in-flight write clears; fifo_full=1 → zero writes.
- Reset pulse in the 3rd beat of a burst → fifo_wr_en=0, gnt_vld=0, rr_ptr=0 immediately (async); after release, arbitration restarts from requester 0.
- Scoreboard check against a model async_fifo (depth 16) under random valid/full stimulus → no write while full, no lost or duplicated beats, per-requester order kept.
